// File: rtl/bf_decode_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bf_decode_sched_if : requester, response and decoder bundle for the     |
// |                      bit-flipping decoder scheduler.   Rev 1.0          |
// +-------------------------------------------------------------------------+
interface bf_decode_sched_if #(
  parameter int R     = 127,
  parameter int W     = 5,
  parameter int POS_W = 8,
  parameter int NREQ  = 2,
  parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*R-1:0]       req_s;
  logic [NREQ*W*POS_W-1:0] req_h0;
  logic [NREQ*W*POS_W-1:0] req_h1;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [R-1:0]            rsp_e0;
  logic [R-1:0]            rsp_e1;
  logic                    rsp_success;
  logic                    rsp_timeout;

  logic                    dec_start;
  logic                    dec_abort;
  logic [R-1:0]            dec_s;
  logic [W*POS_W-1:0]      dec_h0;
  logic [W*POS_W-1:0]      dec_h1;
  logic                    dec_done;
  logic                    dec_success;
  logic [R-1:0]            dec_e0;
  logic [R-1:0]            dec_e1;

  logic                    busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_s, req_h0, req_h1, rsp_ready,
           dec_done, dec_success, dec_e0, dec_e1,
    output req_ready, rsp_valid, rsp_id, rsp_e0, rsp_e1, rsp_success, rsp_timeout,
           dec_start, dec_abort, dec_s, dec_h0, dec_h1, busy
  );

  // Requesters, response consumer and decoder side.
  modport master (
    output req_valid, req_s, req_h0, req_h1, rsp_ready,
           dec_done, dec_success, dec_e0, dec_e1,
    input  req_ready, rsp_valid, rsp_id, rsp_e0, rsp_e1, rsp_success, rsp_timeout,
           dec_start, dec_abort, dec_s, dec_h0, dec_h1, busy
  );
endinterface
`default_nettype wire

// File: rtl/bf_decode_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bf_decode_sched : round-robin sharing of one bit-flipping decoder       |
// |                   between NREQ requesters, with hang watchdog. Rev 1.0  |
// +-------------------------------------------------------------------------+
module bf_decode_sched #(
  parameter int R       = 127,
  parameter int W       = 5,
  parameter int POS_W   = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20000,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bf_decode_sched_if.slave   bus
);
  localparam int              ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_W-1:0] C_WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] C_RR_INIT = ID_W'(NREQ - 1);
  localparam logic [NREQ-1:0] C_ONE     = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ABORT   = 3'd3,
    S_RELEASE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    id_q;
  logic [TO_W-1:0]    wd_q;
  logic               abort_cnt_q;
  logic               dec_start_q;
  logic               dec_abort_q;
  logic [R-1:0]       dec_s_q;
  logic [W*POS_W-1:0] dec_h0_q;
  logic [W*POS_W-1:0] dec_h1_q;
  logic               rsp_valid_q;
  logic [R-1:0]       rsp_e0_q;
  logic [R-1:0]       rsp_e1_q;
  logic               rsp_success_q;
  logic               rsp_timeout_q;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_go;
  int                 cand;

  // Search starts one past the last served index so every other valid requester goes first.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(rr_q) + i) % NREQ;
      if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  assign grant_go      = (state_q == S_IDLE) && grant_vld && !bus.dec_done;
  assign bus.req_ready = grant_go ? (C_ONE << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= C_RR_INIT;
      id_q          <= '0;
      wd_q          <= '0;
      abort_cnt_q   <= 1'b0;
      dec_start_q   <= 1'b0;
      dec_abort_q   <= 1'b0;
      dec_s_q       <= '0;
      dec_h0_q      <= '0;
      dec_h1_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_e0_q      <= '0;
      rsp_e1_q      <= '0;
      rsp_success_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_go) begin
            dec_s_q  <= bus.req_s[grant_idx*R +: R];
            dec_h0_q <= bus.req_h0[grant_idx*W*POS_W +: W*POS_W];
            dec_h1_q <= bus.req_h1[grant_idx*W*POS_W +: W*POS_W];
            id_q     <= grant_idx;
            rr_q     <= grant_idx;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dec_start_q <= 1'b1;
          wd_q        <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (wd_q != C_WD_LAST) begin
            wd_q <= wd_q + 1'b1;
          end
          // A late done still counts as a real result, even on the timeout cycle.
          if (bus.dec_done) begin
            rsp_e0_q      <= bus.dec_e0;
            rsp_e1_q      <= bus.dec_e1;
            rsp_success_q <= bus.dec_success;
            rsp_timeout_q <= 1'b0;
            dec_start_q   <= 1'b0;
            state_q       <= S_RELEASE;
          end else if (wd_q == C_WD_LAST) begin
            dec_start_q   <= 1'b0;
            dec_abort_q   <= 1'b1;
            rsp_e0_q      <= '0;
            rsp_e1_q      <= '0;
            rsp_success_q <= 1'b0;
            rsp_timeout_q <= 1'b1;
            abort_cnt_q   <= 1'b0;
            state_q       <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (!abort_cnt_q) begin
            abort_cnt_q <= 1'b1;
          end else begin
            abort_cnt_q <= 1'b0;
            dec_abort_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RELEASE: begin
          if (!bus.dec_done) begin
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dec_start   = dec_start_q;
  assign bus.dec_abort   = dec_abort_q;
  assign bus.dec_s       = dec_s_q;
  assign bus.dec_h0      = dec_h0_q;
  assign bus.dec_h1      = dec_h1_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_e0      = rsp_e0_q;
  assign bus.rsp_e1      = rsp_e1_q;
  assign bus.rsp_success = rsp_success_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule
`default_nettype wire
